// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction RAM address and
// hides the RAM's one-cycle registered-address latency behind a valid/ready output.
//
// state | meaning
// IDLE  | no fetch in flight, ins_valid low
// READ  | RAM latched pc on the last edge; ram_data is valid this cycle
// VALID | ins_out holds a fetched instruction, waiting for ins_ready
module ins_fetch_unit #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  fetch_req,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]      ram_data,
    output logic [WIDTH-1:0]      ins_out,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  wrapped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    // Explicit last-address compare keeps wrap correct for non-power-of-two depths.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  pc_at_last;

    assign pc_at_last = (pc == LAST_ADDR);
    assign pc_next    = pc_at_last ? '0 : pc + ADDR_WIDTH'(1);
    assign ram_addr   = pc;
    assign pc_out     = pc;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            pc        <= '0;
            ins_out   <= '0;
            ins_valid <= 1'b0;
            wrapped   <= 1'b0;
        end else if (pc_load) begin
            // A load flushes whatever is in flight, including an unaccepted instruction.
            pc        <= pc_in;
            wrapped   <= 1'b0;
            ins_valid <= 1'b0;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) state <= READ;
                end
                READ: begin
                    ins_out   <= ram_data;
                    ins_valid <= 1'b1;
                    pc        <= pc_next;
                    if (pc_at_last) wrapped <= 1'b1;
                    state     <= VALID;
                end
                VALID: begin
                    if (ins_ready) begin
                        ins_valid <= 1'b0;
                        state     <= fetch_req ? READ : IDLE;
                    end
                end
                default: begin
                    ins_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: directed vector table, async reset sequence, and
// randomized traffic against a transaction-level reference model.
module tb_ins_fetch_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic            clk = 1'b0;
    logic            rstN;
    logic            fetch_req, pc_load, ins_ready;
    logic [AW-1:0]   pc_in, ram_addr, pc_out;
    logic [WIDTH-1:0] ram_data, ins_out;
    logic            ins_valid, wrapped;

    logic [WIDTH-1:0] mem [DEPTH];

    int vectors    = 0;
    int miscompares = 0;

    ins_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstN(rstN), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_in(pc_in), .ram_addr(ram_addr), .ram_data(ram_data),
        .ins_out(ins_out), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .pc_out(pc_out), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    // Registered-address RAM: data appears the cycle after the address edge.
    always @(posedge clk) ram_data <= mem[ram_addr];

    typedef struct {
        logic       fr;
        logic       ld;
        logic [7:0] pin;
        logic       rdy;
        logic       ev;
        logic [7:0] eins;
        logic [7:0] epc;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fr, input logic ld, input logic [7:0] pin, input logic rdy,
                       input logic ev, input logic [7:0] eins, input logic [7:0] epc, input logic ew);
        vec_t v;
        v.fr = fr; v.ld = ld; v.pin = pin; v.rdy = rdy;
        v.ev = ev; v.eins = eins; v.epc = epc; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fr, input logic ld, input logic [7:0] pin, input logic rdy);
        fetch_req = fr; pc_load = ld; pc_in = pin; ins_ready = rdy;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 0);
        @(negedge clk);
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: plain integers, phase flags instead of a state encoding.
    int  m_pc, m_addr;
    bit  m_pending, m_have, m_wrap;
    int  m_ins;

    task automatic model_reset();
        m_pc = 0; m_addr = 0; m_pending = 0; m_have = 0; m_wrap = 0; m_ins = 0;
    endtask

    task automatic model_step(input bit fr, input bit ld, input int pin, input bit rdy);
        if (ld) begin
            m_pc = pin % DEPTH; m_wrap = 0; m_pending = 0; m_have = 0;
        end else if (m_pending) begin
            m_ins = mem[m_addr];
            m_have = 1; m_pending = 0;
            if (m_pc == DEPTH - 1) m_wrap = 1;
            m_pc = (m_pc + 1) % DEPTH;
        end else if (m_have) begin
            if (rdy) begin
                m_have = 0;
                if (fr) begin m_pending = 1; m_addr = m_pc; end
            end
        end else if (fr) begin
            m_pending = 1; m_addr = m_pc;
        end
    endtask

    initial begin
        rstN = 1'b0;
        drive(0, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i ^ 8'h3C);
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        mem[8'h40] = 8'h5E; mem[255] = 8'h7F;

        #2;
        check("reset_valid", ins_valid, 0);
        check("reset_pc", pc_out, 0);
        check("reset_addr", ram_addr, 0);
        check("reset_ins", ins_out, 0);
        check("reset_wrapped", wrapped, 0);
        rstN = 1'b1;
        @(posedge clk); #1;

        //  fr ld pin    rdy  ev ins    pc     w
        add(1, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0);   // IDLE -> READ
        add(0, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 0);   // capture word 0
        add(0, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 0);   // backpressure x5
        add(1, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 0);
        add(0, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 0);
        add(1, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 0);
        add(0, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 0);
        add(0, 0, 8'h00, 1,   0, 8'hA1, 8'h01, 0);   // released to IDLE
        add(0, 1, 8'h00, 0,   0, 8'hA1, 8'h00, 0);   // pc back to 0
        add(1, 0, 8'h00, 1,   0, 8'hA1, 8'h00, 0);   // back-to-back stream
        add(1, 0, 8'h00, 1,   1, 8'hA1, 8'h01, 0);
        add(1, 0, 8'h00, 1,   0, 8'hA1, 8'h01, 0);
        add(1, 0, 8'h00, 1,   1, 8'hB2, 8'h02, 0);
        add(1, 0, 8'h00, 1,   0, 8'hB2, 8'h02, 0);
        add(1, 0, 8'h00, 1,   1, 8'hC3, 8'h03, 0);
        add(0, 0, 8'h00, 1,   0, 8'hC3, 8'h03, 0);
        add(1, 0, 8'h00, 0,   0, 8'hC3, 8'h03, 0);   // READ of pc 3 ...
        add(0, 1, 8'h40, 0,   0, 8'hC3, 8'h40, 0);   // ... flushed by jump
        add(0, 0, 8'h00, 0,   0, 8'hC3, 8'h40, 0);   // no stale valid
        add(1, 0, 8'h00, 0,   0, 8'hC3, 8'h40, 0);
        add(0, 0, 8'h00, 0,   1, 8'h5E, 8'h41, 0);
        add(0, 0, 8'h00, 1,   0, 8'h5E, 8'h41, 0);
        add(0, 1, 8'hFF, 0,   0, 8'h5E, 8'hFF, 0);   // wrap case
        add(1, 0, 8'h00, 0,   0, 8'h5E, 8'hFF, 0);
        add(0, 0, 8'h00, 0,   1, 8'h7F, 8'h00, 1);
        add(0, 0, 8'h00, 1,   0, 8'h7F, 8'h00, 1);   // wrapped is sticky
        add(1, 0, 8'h00, 0,   0, 8'h7F, 8'h00, 1);
        add(0, 0, 8'h00, 0,   1, 8'hA1, 8'h01, 1);
        add(0, 1, 8'h05, 1,   0, 8'hA1, 8'h05, 0);   // load beats ready in VALID
        add(1, 1, 8'h02, 0,   0, 8'hA1, 8'h02, 0);   // load beats fetch in IDLE
        add(0, 0, 8'h00, 0,   0, 8'hA1, 8'h02, 0);   // still IDLE
        add(0, 0, 8'h00, 1,   0, 8'hA1, 8'h02, 0);   // ready outside VALID ignored

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fr, vecs[i].ld, vecs[i].pin, vecs[i].rdy);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), ins_valid, vecs[i].ev);
            check($sformatf("vec%0d_ins", i), ins_out, vecs[i].eins);
            check($sformatf("vec%0d_pc", i), pc_out, vecs[i].epc);
            check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].epc);
            check($sformatf("vec%0d_wrapped", i), wrapped, vecs[i].ew);
        end

        // Async reset while VALID with wrapped set: must clear between edges.
        drive(0, 1, 8'hFF, 0); @(posedge clk); #1;
        drive(1, 0, 8'h00, 0); @(posedge clk); #1;
        drive(0, 0, 8'h00, 0); @(posedge clk); #1;
        check("pre_rst_valid", ins_valid, 1);
        check("pre_rst_wrapped", wrapped, 1);
        #3 rstN = 1'b0;
        #1;
        check("async_rst_valid", ins_valid, 0);
        check("async_rst_pc", pc_out, 0);
        check("async_rst_ins", ins_out, 0);
        check("async_rst_wrapped", wrapped, 0);
        #2 rstN = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", ins_valid, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit fr, ld, rdy;
            int pin;
            fr  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            pin = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 255 : 254) : $urandom_range(0, 255);
            drive(fr, ld, 8'(pin), rdy);
            model_step(fr, ld, pin, rdy);
            @(posedge clk); #1;
            check("rnd_valid", ins_valid, int'(m_have));
            check("rnd_pc", pc_out, m_pc);
            check("rnd_addr", ram_addr, m_pc);
            check("rnd_wrapped", wrapped, int'(m_wrap));
            if (m_have) check("rnd_ins", ins_out, m_ins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
